// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MIPS load/store unit driving a word-wide RAM without byte enables.
// Sub-word stores become a read-modify-write; LWL/LWR merge the captured word with rt.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_rt,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data_in,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_data_out
);

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_LWL = 4'd5;
  localparam logic [3:0] OP_LWR = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rt_q, rt_d;
  logic [31:0]       word_q, word_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic              req_illegal;
  logic              req_misaligned;
  logic [31:0]       merged_word;

  function automatic logic [31:0] load_fmt(input logic [3:0] op, input logic [1:0] b,
                                           input logic [31:0] w, input logic [31:0] rt);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] lmask;
    logic [31:0] rmask;
    byte_v = w[{b, 3'b000} +: 8];
    half_v = w[{b[1], 4'b0000} +: 16];
    // Shift of 32 when b=3 empties the LWL keep-mask, so the whole word comes from memory.
    lmask  = 32'hFFFF_FFFF >> ({1'b0, b, 3'b000} + 6'd8);
    rmask  = 32'hFFFF_FFFF >> {b, 3'b000};
    case (op)
      OP_LB:   load_fmt = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  load_fmt = {24'd0, byte_v};
      OP_LH:   load_fmt = {{16{half_v[15]}}, half_v};
      OP_LHU:  load_fmt = {16'd0, half_v};
      OP_LWL:  load_fmt = (w << (6'd24 - {1'b0, b, 3'b000})) | (rt & lmask);
      OP_LWR:  load_fmt = (w >> {b, 3'b000}) | (rt & ~rmask);
      default: load_fmt = w;
    endcase
  endfunction

  always_comb begin
    req_illegal    = !(req_op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR,
                                      OP_SB, OP_SH, OP_SW});
    req_misaligned = ((req_op == OP_LH || req_op == OP_LHU || req_op == OP_SH) && req_addr[0]) ||
                     ((req_op == OP_LW || req_op == OP_SW) && (req_addr[1:0] != 2'b00));
  end

  always_comb begin
    merged_word = word_q;
    if (op_q == OP_SB) begin
      merged_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (op_q == OP_SH) begin
      merged_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rt_d         = rt_q;
    word_d       = word_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'd0;
    resp_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rt_d    = req_rt;
          if (req_illegal || req_misaligned) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (req_op == OP_SW) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        word_d = mem_data_out;
        if (op_q <= OP_LWR) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_fmt(op_q, addr_q[1:0], mem_data_out, rt_q);
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      op_q         <= 4'd0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      rt_q         <= 32'd0;
      word_q       <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rt_q         <= rt_d;
      word_q       <= word_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Memory strobes decode from state alone, so a reset drops them without waiting for a clock.
  assign req_ready   = (state_q == S_IDLE);
  assign mem_read    = (state_q == S_READ);
  assign mem_write   = (state_q == S_WRITE);
  assign mem_addr    = (mem_read || mem_write) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_data_in = mem_write ? ((op_q == OP_SW) ? wdata_q : merged_word) : 32'd0;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit against a byte-addressed model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_rt;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_data_out;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_rt(req_rt),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_read(mem_read),
    .mem_write(mem_write), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:255];
  assign mem_data_out = ram[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) ram[mem_addr[9:2]] <= mem_data_in;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        expq[$];
  logic [7:0]  mbytes [0:1023];
  int          cycle = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_waddr = 32'd0;
  logic [31:0] last_rdata = 32'd0;
  logic        last_err = 1'b0;
  int          last_resp_cycle = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wr_data = 32'd0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cycle);
    end
  endtask

  function automatic logic [7:0] rdb(input logic [31:0] a);
    return mbytes[a[9:0]];
  endfunction

  task automatic wrb(input logic [31:0] a, input logic [7:0] v);
    mbytes[a[9:0]] = v;
  endtask

  // Reference behaviour expressed as byte-level memory operations.
  task automatic model_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rt, output logic [31:0] rd, output logic er,
                           output int lat);
    int          k;
    logic [31:0] base;
    logic [7:0]  bv;
    logic [15:0] hv;
    rd = 32'd0; er = 1'b0; lat = 2;
    k = int'(a[1:0]);
    base = {a[31:2], 2'b00};
    if (!(op inside {[4'd0:4'd6], [4'd8:4'd10]}) ||
        ((op == 4'd2 || op == 4'd3 || op == 4'd9) && (k % 2 != 0)) ||
        ((op == 4'd4 || op == 4'd10) && k != 0)) begin
      er = 1'b1; lat = 1;
      return;
    end
    bv = rdb(a);
    hv = {rdb(a + 1), rdb(a)};
    case (op)
      4'd0: rd = {{24{bv[7]}}, bv};
      4'd1: rd = {24'd0, bv};
      4'd2: rd = {{16{hv[15]}}, hv};
      4'd3: rd = {16'd0, hv};
      4'd4: rd = {rdb(a + 3), rdb(a + 2), rdb(a + 1), rdb(a)};
      4'd5: begin
        rd = rt;
        for (int i = 0; i <= k; i++) rd[8*(3-k+i) +: 8] = rdb(base + i);
      end
      4'd6: begin
        rd = rt;
        for (int i = k; i <= 3; i++) rd[8*(i-k) +: 8] = rdb(base + i);
      end
      4'd8: begin wrb(a, wd[7:0]); lat = 3; end
      4'd9: begin wrb(a, wd[7:0]); wrb(a + 1, wd[15:8]); lat = 3; end
      default: for (int i = 0; i < 4; i++) wrb(a + i, wd[8*i +: 8]);
    endcase
  endtask

  task automatic do_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rt, input bit hold, output int acc);
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;
    exp_t        e;
    @(negedge clk);
    req_op = op; req_addr = a; req_wdata = wd; req_rt = rt; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready stayed %b, required 1", req_ready);
      req_valid = 1'b0; acc = -1;
      return;
    end
    @(posedge clk); #1;
    acc = cycle;
    cur_waddr = {a[31:2], 2'b00};
    model_req(op, a, wd, rt, rd, er, lat);
    e.due = acc + lat - 1; e.rdata = rd; e.err = er;
    expq.push_back(e);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (expq.size() != 0 && n < 40) begin @(negedge clk); n++; end
    #1;
    if (expq.size() != 0) begin
      checks++; errors++;
      $display("FAIL resp_timeout: %0d responses outstanding, required 0", expq.size());
      expq.delete();
    end
  endtask

  // Per-cycle compare against the model's expected response queue.
  always @(negedge clk) begin
    if (reset_n) begin
      if (expq.size() > 0 && expq[0].due < cycle) begin
        checks++; errors++;
        $display("FAIL resp_missing: no resp_valid at cycle %0d, required one", expq[0].due);
        void'(expq.pop_front());
      end
      if (expq.size() > 0 && expq[0].due == cycle) begin
        check("resp_valid", {63'd0, resp_valid}, 64'd1);
        check("resp_rdata", {32'd0, resp_rdata}, {32'd0, expq[0].rdata});
        check("resp_err", {63'd0, resp_err}, {63'd0, expq[0].err});
        void'(expq.pop_front());
      end else begin
        check("resp_quiet", {30'd0, resp_valid, resp_err, resp_rdata}, 64'd0);
      end
      check("strobe_excl", {63'd0, mem_read & mem_write}, 64'd0);
      if (mem_read || mem_write) check("mem_addr", {32'd0, mem_addr}, {32'd0, cur_waddr});
      else check("mem_addr_idle", {32'd0, mem_addr}, 64'd0);
      if (!mem_write) check("mem_data_in_idle", {32'd0, mem_data_in}, 64'd0);
      if (mem_read) rd_cnt++;
      if (mem_write) begin wr_cnt++; last_wr_data = mem_data_in; end
      if (resp_valid) begin
        last_rdata = resp_rdata; last_err = resp_err; last_resp_cycle = cycle;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] rt;
    logic [31:0] exp;
    logic        err;
    int          lat;
  } vec_t;

  initial begin
    vec_t vecs[$];
    int   acc, acc2, r0, w0;

    reset_n = 1'b0; req_valid = 1'b0; req_op = 4'd0;
    req_addr = 32'd0; req_wdata = 32'd0; req_rt = 32'd0;
    @(negedge clk); @(negedge clk);
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_outputs", {mem_read, mem_write, resp_valid, resp_err, resp_rdata},
          64'd0);
    check("rst_mem_bus", {mem_addr, mem_data_in}, 64'd0);
    reset_n = 1'b1;

    do_req(4'd10, 32'h100, 32'h8899AABB, 32'd0, 1'b0, acc);
    wait_idle();
    check("preload_ram", {32'd0, ram[64]}, {32'd0, 32'h8899AABB});

    // op, addr, rt, expected rdata, expected err, expected latency
    vecs.push_back('{4'd0, 32'h101, 32'h0,        32'hFFFFFFAA, 1'b0, 2});
    vecs.push_back('{4'd1, 32'h101, 32'h0,        32'h000000AA, 1'b0, 2});
    vecs.push_back('{4'd5, 32'h101, 32'h01020304, 32'hAABB0304, 1'b0, 2});
    vecs.push_back('{4'd6, 32'h101, 32'h01020304, 32'h018899AA, 1'b0, 2});
    vecs.push_back('{4'd5, 32'h103, 32'h01020304, 32'h8899AABB, 1'b0, 2});
    vecs.push_back('{4'd6, 32'h100, 32'h01020304, 32'h8899AABB, 1'b0, 2});
    vecs.push_back('{4'd2, 32'h102, 32'h0,        32'hFFFF8899, 1'b0, 2});
    vecs.push_back('{4'd3, 32'h100, 32'h0,        32'h0000AABB, 1'b0, 2});
    vecs.push_back('{4'd2, 32'h103, 32'h0,        32'h00000000, 1'b1, 1});
    vecs.push_back('{4'd7, 32'h100, 32'h0,        32'h00000000, 1'b1, 1});
    vecs.push_back('{4'd10, 32'h106, 32'h0,       32'h00000000, 1'b1, 1});
    foreach (vecs[i]) begin
      r0 = rd_cnt; w0 = wr_cnt;
      do_req(vecs[i].op, vecs[i].addr, 32'h12345678, vecs[i].rt, 1'b0, acc);
      wait_idle();
      check($sformatf("vec%0d_rdata", i), {32'd0, last_rdata}, {32'd0, vecs[i].exp});
      check($sformatf("vec%0d_err", i), {63'd0, last_err}, {63'd0, vecs[i].err});
      check($sformatf("vec%0d_latency", i), 64'(last_resp_cycle - acc), 64'(vecs[i].lat - 1));
      check($sformatf("vec%0d_reads", i), 64'(rd_cnt - r0), vecs[i].err ? 64'd0 : 64'd1);
      check($sformatf("vec%0d_writes", i), 64'(wr_cnt - w0), 64'd0);
    end

    r0 = rd_cnt; w0 = wr_cnt;
    do_req(4'd8, 32'h102, 32'h12345677, 32'd0, 1'b0, acc);
    wait_idle();
    check("sb_latency", 64'(last_resp_cycle - acc), 64'd2);
    check("sb_rmw_strobes", {32'(rd_cnt - r0), 32'(wr_cnt - w0)}, {32'd1, 32'd1});
    check("sb_write_data", {32'd0, last_wr_data}, {32'd0, 32'h8877AABB});
    do_req(4'd4, 32'h100, 32'd0, 32'd0, 1'b0, acc);
    wait_idle();
    check("sb_readback", {32'd0, last_rdata}, {32'd0, 32'h8877AABB});

    // Reset lands during the WRITE phase of an SH; the store must be abandoned.
    @(negedge clk);
    req_op = 4'd9; req_addr = 32'h100; req_wdata = 32'h0000BEEF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; cur_waddr = 32'h100;
    @(posedge clk); #2;
    check("sh_in_write", {63'd0, mem_write}, 64'd1);
    reset_n = 1'b0;
    #1;
    check("rst_write_drop", {62'd0, mem_write, mem_read}, 64'd0);
    check("rst_ready_mid", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_ready_after", {63'd0, req_ready}, 64'd1);
    check("rst_ram_unchanged", {32'd0, ram[64]}, {32'd0, 32'h8877AABB});
    do_req(4'd4, 32'h100, 32'd0, 32'd0, 1'b0, acc);
    wait_idle();
    check("rst_readback", {32'd0, last_rdata}, {32'd0, 32'h8877AABB});

    do_req(4'd10, 32'h104, 32'hCAFEF00D, 32'd0, 1'b1, acc);
    do_req(4'd4, 32'h104, 32'd0, 32'd0, 1'b0, acc2);
    wait_idle();
    check("b2b_accept_cycle", 64'(acc2 - acc), 64'd3);
    check("b2b_rdata", {32'd0, last_rdata}, {32'd0, 32'hCAFEF00D});

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the CPU datapath (MEM stage) and RAM_module; it is the only master driving RAM_module's addr, data_in, data_read and data_write.
- Converts MIPS byte, halfword, word and unaligned loads/stores (LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW) into aligned 32-bit RAM accesses.
- RAM_module has no byte enables, so sub-word stores are done as a sequenced read-modify-write.
- Memory is little-endian: byte at address A occupies bits [8*(A%4)+7 : 8*(A%4)] of the word at address A&~3.

Parameters:
- ADDR_W, 32, CPU/RAM byte-address width.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  CPU presents a request.
- req_ready  output  1  unit idle; a request is accepted when req_valid && req_ready.
- req_op  input  4  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 8 SB, 9 SH, 10 SW; any other value is illegal.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data (rt), right-justified.
- req_rt  input  32  current rt value, used for the LWL/LWR merge.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  load result; 0 for stores and errors.
- resp_err  output  1  misaligned access or illegal op; valid with resp_valid.
- mem_addr  output  ADDR_W  to RAM addr; always {req_addr[ADDR_W-1:2],2'b00} of the latched request while accessing, else 0.
- mem_data_in  output  32  to RAM data_in; 0 unless mem_write.
- mem_read  output  1  to RAM data_read.
- mem_write  output  1  to RAM data_write.
- mem_data_out  input  32  from RAM data_out; combinational with mem_addr.

Behaviour:
- States: IDLE, READ, WRITE, RESP.
- req_ready = (state==IDLE).
- mem_read = (state==READ); mem_write = (state==WRITE). Both are decoded from state only, so they are never high together.
- Accept (IDLE, req_valid): latch op, addr, wdata and rt, then branch:
  - illegal op -> RESP with err=1.
  - misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) -> RESP with err=1. No RAM access is made.
  - SW -> WRITE.
  - all loads, SB and SH -> READ.
- READ: capture mem_data_out into a word register at the clock edge.
  - loads -> RESP.
  - SB/SH -> WRITE.
- WRITE drives mem_data_in:
  - SW: wdata.
  - SB: captured word with byte lane addr[1:0] replaced by wdata[7:0].
  - SH: captured word with half lane addr[1] replaced by wdata[15:0].
  - next state RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - Request-to-response latency, counted from the accept edge: error 1 cycle; SW 2; loads 2; SB/SH 3.
- Load data formation, with b=addr[1:0] and W = captured word:
  - LB/LBU: byte b, sign- or zero-extended.
  - LH/LHU: half addr[1], sign- or zero-extended.
  - LW: W.
  - LWL: (W << 8*(3-b)) | (rt & (32'hFFFFFFFF >> 8*(b+1))). The mask is 0 when b=3.
  - LWR: (W >> 8*b) | (rt & ~(32'hFFFFFFFF >> 8*b)).
  - LWL/LWR accept any alignment.
- resp_rdata and resp_err are registered, held 0 outside RESP, and 0 for stores.
- req_valid is ignored while not in IDLE. No queuing.
- Reset (asserted asynchronously at any time, including mid-WRITE):
  - state goes to IDLE; all outputs are 0 except req_ready, which is 1.
  - mem_write falls immediately; the pending store is abandoned.
  - latched registers clear to 0.
- Address wrap: mem_addr is computed from the latched address with no increment, so there is no wrap-around inside the unit.

Test Plan:
- LB and LBU timing: preload word 0x100 = 0x8899AABB. LB addr 0x101 -> resp_rdata 0xFFFFFFAA; LBU addr 0x101 -> 0x000000AA. For each, mem_read is high for one cycle and resp_valid is high 2 cycles after accept.
- SB read-modify-write: SB addr 0x102, wdata 0x12345677. Sequence is READ, WRITE with mem_data_in 0x8877AABB, then RESP at cycle 3. A following LW 0x100 returns 0x8877AABB.
- Misaligned halfword: LH addr 0x103 -> resp_valid with resp_err=1 at cycle 1. mem_read and mem_write stay 0 throughout. Repeat with op 7 (illegal) and expect the same.
- LWL/LWR merge: word 0x100 = 0x8899AABB, rt 0x01020304.
  - LWL addr 0x101 -> 0xAABB0304.
  - LWR addr 0x101 -> 0x018899AA.
  - LWL addr 0x103 -> 0x8899AABB.
  - LWR addr 0x100 -> 0x8899AABB.
- Reset mid-store: SH addr 0x100, wdata 0xBEEF; assert reset_n=0 during WRITE. mem_write drops before the next clock edge, word 0x100 is unchanged, and req_ready=1 after release.
- Back-to-back requests: hold req_valid with SW 0x104 = 0xCAFEF00D, then LW 0x104. The second request is accepted only in the cycle after the first resp_valid, and it returns 0xCAFEF00D.
